decompress_block: RTL and testbench

Inverse of the per-block compression path. Accepts one 8x8 block of quantized coefficients, dequantizes it with the fixed luminance table, and runs a separable 2-D inverse DCT. Row pass and column pass each take one row or column per cycle. Produces a saturated 8x8 block of signed 9-bit level-shifted pixels. It sits on the decoder side, directly after the entropy decoder, and mirrors the forward DCT + quantizer pair.

---
 rtl/codec_pkg.sv | 38 +++
 rtl/decompress_block_if.sv | 10 +
 rtl/idct_dot8.sv | 15 +
 rtl/decompress_block.sv | 67 ++++++
 tb/tb_decompress_block.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/codec_pkg.sv
// codec_pkg: shared codec constants, quantization/IDCT tables, FSM states and pixel saturation.
package codec_pkg;
  localparam int BLOCK_SIZE  = 8;
  localparam int COEFF_WIDTH = 9;
  localparam int PIXEL_WIDTH = 9;
  localparam int MID_WIDTH   = 32;
  localparam int ACC_WIDTH   = 48;
  localparam int DQ_WIDTH    = 17;
  localparam int COS_WIDTH   = 9;
  localparam int FRAC_SHIFT  = 16;
  localparam logic signed [ACC_WIDTH-1:0] ROUND_ADD = 48'sd32768;
  localparam logic signed [ACC_WIDTH-1:0] SAT_HI    = 48'sd255;
  localparam logic signed [ACC_WIDTH-1:0] SAT_LO    = -48'sd256;
  typedef enum logic [1:0] {IDLE, ROW, COL} state_t;
  localparam logic [7:0] QTABLE [BLOCK_SIZE][BLOCK_SIZE] = '{
    '{8'd16, 8'd11, 8'd10, 8'd16, 8'd24,  8'd40,  8'd51,  8'd61},
    '{8'd12, 8'd12, 8'd14, 8'd19, 8'd26,  8'd58,  8'd60,  8'd55},
    '{8'd14, 8'd13, 8'd16, 8'd24, 8'd40,  8'd57,  8'd69,  8'd56},
    '{8'd14, 8'd17, 8'd22, 8'd29, 8'd51,  8'd87,  8'd80,  8'd62},
    '{8'd18, 8'd22, 8'd37, 8'd56, 8'd68,  8'd109, 8'd103, 8'd77},
    '{8'd24, 8'd35, 8'd55, 8'd64, 8'd81,  8'd104, 8'd113, 8'd92},
    '{8'd49, 8'd64, 8'd78, 8'd87, 8'd103, 8'd121, 8'd120, 8'd101},
    '{8'd72, 8'd92, 8'd95, 8'd98, 8'd112, 8'd100, 8'd103, 8'd99}};
  localparam logic signed [COS_WIDTH-1:0] IDCT_COS [BLOCK_SIZE][BLOCK_SIZE] = '{
    '{ 9'sd91,   9'sd91,   9'sd91,   9'sd91,   9'sd91,   9'sd91,   9'sd91,   9'sd91},
    '{ 9'sd126,  9'sd106,  9'sd71,   9'sd25,  -9'sd25,  -9'sd71,  -9'sd106, -9'sd126},
    '{ 9'sd118,  9'sd49,  -9'sd49,  -9'sd118, -9'sd118, -9'sd49,   9'sd49,   9'sd118},
    '{ 9'sd106, -9'sd25,  -9'sd126, -9'sd71,   9'sd71,   9'sd126,  9'sd25,  -9'sd106},
    '{ 9'sd91,  -9'sd91,  -9'sd91,   9'sd91,   9'sd91,  -9'sd91,  -9'sd91,   9'sd91},
    '{ 9'sd71,  -9'sd126,  9'sd25,   9'sd106, -9'sd106, -9'sd25,   9'sd126, -9'sd71},
    '{ 9'sd49,  -9'sd118,  9'sd118, -9'sd49,  -9'sd49,   9'sd118, -9'sd118,  9'sd49},
    '{ 9'sd25,  -9'sd71,   9'sd106, -9'sd126,  9'sd126, -9'sd106,  9'sd71,  -9'sd25}};
  function automatic logic signed [PIXEL_WIDTH-1:0] sat_pixel(input logic signed [ACC_WIDTH-1:0] acc);
    logic signed [ACC_WIDTH-1:0] r;
    r = (acc + ROUND_ADD) >>> FRAC_SHIFT;
    return r > SAT_HI ? SAT_HI[PIXEL_WIDTH-1:0] : r < SAT_LO ? SAT_LO[PIXEL_WIDTH-1:0] : r[PIXEL_WIDTH-1:0];
  endfunction
endpackage

// File: rtl/decompress_block_if.sv
// decompress_block_if: block request/response bundle between entropy decoder and IDCT.
interface decompress_block_if;
  logic start_block;
  logic signed [codec_pkg::COEFF_WIDTH-1:0] quantized_coeffs [codec_pkg::BLOCK_SIZE][codec_pkg::BLOCK_SIZE];
  logic signed [codec_pkg::PIXEL_WIDTH-1:0] pixels_out [codec_pkg::BLOCK_SIZE][codec_pkg::BLOCK_SIZE];
  logic busy;
  logic block_done;
  modport master (output start_block, quantized_coeffs, input pixels_out, busy, block_done);
  modport slave (input start_block, quantized_coeffs, output pixels_out, busy, block_done);
endinterface

// File: rtl/idct_dot8.sv
// idct_dot8: combinational 8-term signed dot product.
module idct_dot8 #(
  parameter int AW = 32,
  parameter int BW = 9,
  parameter int RW = 48
) (
  input  logic signed [AW-1:0] a [8],
  input  logic signed [BW-1:0] b [8],
  output logic signed [RW-1:0] y
);
  always_comb begin
    y = '0;
    for (int i = 0; i < 8; i++) y = y + RW'(a[i]) * RW'(b[i]);
  end
endmodule

// File: rtl/decompress_block.sv
// decompress_block: dequantize an 8x8 block and run a row-then-column 2-D IDCT, one row/column per cycle.
module decompress_block import codec_pkg::*; (
  input logic clk,
  input logic rst,
  decompress_block_if.slave bus
);
  state_t state;
  logic [2:0] cnt;
  logic signed [DQ_WIDTH-1:0] d [BLOCK_SIZE][BLOCK_SIZE];
  logic signed [MID_WIDTH-1:0] t [BLOCK_SIZE][BLOCK_SIZE];
  logic signed [PIXEL_WIDTH-1:0] res [BLOCK_SIZE][BLOCK_SIZE];
  logic signed [MID_WIDTH-1:0] op_a [BLOCK_SIZE];
  logic signed [COS_WIDTH-1:0] cos_b [BLOCK_SIZE][BLOCK_SIZE];
  logic signed [ACC_WIDTH-1:0] dot [BLOCK_SIZE];
  logic signed [PIXEL_WIDTH-1:0] col_pix [BLOCK_SIZE];
  // Both passes weight by column i of IDCT_COS; only the data vector changes with state.
  always_comb
    for (int i = 0; i < BLOCK_SIZE; i++) begin
      op_a[i] = state == COL ? t[i][cnt] : MID_WIDTH'(d[cnt][i]);
      col_pix[i] = sat_pixel(dot[i]);
      for (int j = 0; j < BLOCK_SIZE; j++) cos_b[i][j] = IDCT_COS[j][i];
    end
  for (genvar i = 0; i < BLOCK_SIZE; i++) begin : g_dot
    idct_dot8 #(.AW(MID_WIDTH), .BW(COS_WIDTH), .RW(ACC_WIDTH)) u_dot (.a(op_a), .b(cos_b[i]), .y(dot[i]));
  end
  always_ff @(posedge clk)
    for (int i = 0; i < BLOCK_SIZE; i++)
      for (int j = 0; j < BLOCK_SIZE; j++) begin
        if (state == IDLE && bus.start_block)
          d[i][j] <= DQ_WIDTH'(bus.quantized_coeffs[i][j]) * DQ_WIDTH'($signed({1'b0, QTABLE[i][j]}));
        if (state == ROW && j == 0) t[cnt][i] <= MID_WIDTH'(dot[i]);
        if (state == COL && j == 0) res[i][cnt] <= col_pix[i];
      end
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      bus.busy <= 1'b0;
      bus.block_done <= 1'b0;
      for (int m = 0; m < BLOCK_SIZE; m++)
        for (int n = 0; n < BLOCK_SIZE; n++) bus.pixels_out[m][n] <= '0;
    end else begin
      bus.block_done <= 1'b0;
      case (state)
        IDLE: if (bus.start_block) begin
          state <= ROW;
          cnt <= '0;
          bus.busy <= 1'b1;
        end
        ROW: begin
          cnt <= cnt + 3'd1;
          state <= cnt == 3'd7 ? COL : ROW;
        end
        COL: begin
          cnt <= cnt + 3'd1;
          if (cnt == 3'd7) begin
            state <= IDLE;
            bus.busy <= 1'b0;
            bus.block_done <= 1'b1;
            for (int m = 0; m < BLOCK_SIZE; m++)
              for (int n = 0; n < BLOCK_SIZE; n++) bus.pixels_out[m][n] <= n == 7 ? col_pix[m] : res[m][n];
          end
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_decompress_block.sv
// tb_decompress_block: directed and model-based checks of decompress_block.
module tb_decompress_block;
  import codec_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  int bad_m = 0, bad_n = 0;
  logic signed [8:0] cin [8][8];
  logic signed [8:0] exp_pix [8][8];
  longint cm [8][8];

  decompress_block_if bus();
  decompress_block dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_dc(input int dc);
    for (int u = 0; u < 8; u++)
      for (int v = 0; v < 8; v++) cin[u][v] = '0;
    cin[0][0] = 9'(dc);
  endtask

  task automatic fill_exp(input int val);
    for (int m = 0; m < 8; m++)
      for (int n = 0; n < 8; n++) exp_pix[m][n] = 9'(val);
  endtask

  function automatic int pix_diff();
    int nb = 0;
    for (int m = 0; m < 8; m++)
      for (int n = 0; n < 8; n++)
        if (bus.pixels_out[m][n] !== exp_pix[m][n]) begin
          if (nb == 0) begin bad_m = m; bad_n = n; end
          nb++;
        end
    return nb;
  endfunction

  // Independent fixed-point reference: dequantize, row pass, column pass, round, saturate.
  task automatic model();
    longint d [8][8];
    longint t [8][8];
    longint p, r;
    for (int u = 0; u < 8; u++)
      for (int v = 0; v < 8; v++) d[u][v] = longint'(cin[u][v]) * longint'(QTABLE[u][v]);
    for (int u = 0; u < 8; u++)
      for (int n = 0; n < 8; n++) begin
        t[u][n] = 0;
        for (int v = 0; v < 8; v++) t[u][n] += d[u][v] * cm[v][n];
      end
    for (int m = 0; m < 8; m++)
      for (int n = 0; n < 8; n++) begin
        p = 0;
        for (int u = 0; u < 8; u++) p += cm[u][m] * t[u][n];
        r = (p + 32768) >>> 16;
        exp_pix[m][n] = 9'(r > 255 ? 255 : r < -256 ? -256 : r);
      end
  endtask

  task automatic run_block(output int lat, output int busy_err);
    bus.quantized_coeffs = cin;
    bus.start_block = 1'b1;
    tick();
    bus.start_block = 1'b0;
    for (int u = 0; u < 8; u++)
      for (int v = 0; v < 8; v++) bus.quantized_coeffs[u][v] = 9'($urandom_range(0, 511));
    lat = 0;
    busy_err = 0;
    while (bus.block_done !== 1'b1 && lat < 40) begin
      if (bus.busy !== 1'b1) busy_err++;
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    int nb;
    rst = 1'b1;
    tick();
    tick();
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    checks++; if (bus.block_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", bus.block_done); end
    fill_exp(0);
    nb = pix_diff();
    checks++; if (nb != 0) begin errors++; $display("FAIL reset_pixels [%0d][%0d] got %0d want 0", bad_m, bad_n, bus.pixels_out[bad_m][bad_n]); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_dc();
    int lat, be, nb;
    set_dc(1);
    run_block(lat, be);
    checks++; if (lat != 16) begin errors++; $display("FAIL dc_latency got %0d want 16", lat); end
    checks++; if (be != 0) begin errors++; $display("FAIL dc_busy_low_cycles got %0d want 0", be); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL dc_busy_at_done got %b want 0", bus.busy); end
    fill_exp(2);
    nb = pix_diff();
    checks++; if (nb != 0) begin errors++; $display("FAIL dc_pixels [%0d][%0d] got %0d want 2", bad_m, bad_n, bus.pixels_out[bad_m][bad_n]); end
    tick();
    checks++; if (bus.block_done !== 1'b0) begin errors++; $display("FAIL dc_done_pulse got %b want 0", bus.block_done); end
    nb = pix_diff();
    checks++; if (nb != 0) begin errors++; $display("FAIL dc_hold [%0d][%0d] got %0d want 2", bad_m, bad_n, bus.pixels_out[bad_m][bad_n]); end
  endtask

  task automatic test_ac();
    int lat, be, nb;
    int row [8] = '{2, 2, 1, 0, 0, -1, -2, -2};
    set_dc(0);
    cin[0][1] = 9'sd1;
    for (int m = 0; m < 8; m++)
      for (int n = 0; n < 8; n++) exp_pix[m][n] = 9'(row[n]);
    run_block(lat, be);
    checks++; if (lat != 16) begin errors++; $display("FAIL ac_latency got %0d want 16", lat); end
    nb = pix_diff();
    checks++; if (nb != 0) begin errors++; $display("FAIL ac_pixels [%0d][%0d] got %0d want %0d", bad_m, bad_n, bus.pixels_out[bad_m][bad_n], exp_pix[bad_m][bad_n]); end
  endtask

  task automatic test_back_to_back();
    int lat, be, nb;
    set_dc(0);
    run_block(lat, be);
    fill_exp(0);
    nb = pix_diff();
    checks++; if (nb != 0) begin errors++; $display("FAIL zero_pixels [%0d][%0d] got %0d want 0", bad_m, bad_n, bus.pixels_out[bad_m][bad_n]); end
    set_dc(-256);
    run_block(lat, be);
    checks++; if (lat != 16) begin errors++; $display("FAIL b2b_latency got %0d want 16", lat); end
    fill_exp(-256);
    nb = pix_diff();
    checks++; if (nb != 0) begin errors++; $display("FAIL sat_low_pixels [%0d][%0d] got %0d want -256", bad_m, bad_n, bus.pixels_out[bad_m][bad_n]); end
  endtask

  task automatic test_saturation();
    int lat, be, nb;
    tick();
    set_dc(255);
    run_block(lat, be);
    fill_exp(255);
    nb = pix_diff();
    checks++; if (nb != 0) begin errors++; $display("FAIL sat_high_pixels [%0d][%0d] got %0d want 255", bad_m, bad_n, bus.pixels_out[bad_m][bad_n]); end
  endtask

  task automatic test_start_held();
    int pulses = 0, first = -1, second = -1, nb;
    tick();
    set_dc(1);
    bus.quantized_coeffs = cin;
    bus.start_block = 1'b1;
    tick();
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (n == 4) begin
        for (int u = 0; u < 8; u++)
          for (int v = 0; v < 8; v++) bus.quantized_coeffs[u][v] = '0;
        bus.quantized_coeffs[0][0] = 9'sd255;
      end
      if (bus.block_done === 1'b1) begin
        pulses++;
        if (pulses == 1) first = n; else second = n;
        fill_exp(pulses == 1 ? 2 : 255);
        nb = pix_diff();
        checks++; if (nb != 0) begin errors++; $display("FAIL held_pixels pulse %0d [%0d][%0d] got %0d want %0d", pulses, bad_m, bad_n, bus.pixels_out[bad_m][bad_n], exp_pix[bad_m][bad_n]); end
      end
      if (n == 33) bus.start_block = 1'b0;
    end
    checks++; if (pulses != 2) begin errors++; $display("FAIL held_pulses got %0d want 2", pulses); end
    checks++; if (first != 16 || second != 33) begin errors++; $display("FAIL held_timing got %0d,%0d want 16,33", first, second); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL held_busy_end got %b want 0", bus.busy); end
  endtask

  task automatic test_reset_mid();
    int lat, be, nb, pulses = 0;
    set_dc(1);
    bus.quantized_coeffs = cin;
    bus.start_block = 1'b1;
    tick();
    bus.start_block = 1'b0;
    for (int n = 1; n <= 8; n++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", bus.busy); end
    fill_exp(0);
    nb = pix_diff();
    checks++; if (nb != 0) begin errors++; $display("FAIL midrst_pixels [%0d][%0d] got %0d want 0", bad_m, bad_n, bus.pixels_out[bad_m][bad_n]); end
    for (int n = 0; n < 20; n++) begin
      if (bus.block_done !== 1'b0) pulses++;
      tick();
    end
    checks++; if (pulses != 0) begin errors++; $display("FAIL midrst_done got %0d pulses want 0", pulses); end
    run_block(lat, be);
    checks++; if (lat != 16 || be != 0) begin errors++; $display("FAIL midrst_rerun lat %0d busy_err %0d want 16 0", lat, be); end
    fill_exp(2);
    nb = pix_diff();
    checks++; if (nb != 0) begin errors++; $display("FAIL midrst_rerun_pixels [%0d][%0d] got %0d want 2", bad_m, bad_n, bus.pixels_out[bad_m][bad_n]); end
  endtask

  task automatic test_random();
    int lat, be, nb;
    logic signed [4:0] sm;
    for (int b = 0; b < 200; b++) begin
      for (int u = 0; u < 8; u++)
        for (int v = 0; v < 8; v++) begin
          sm = 5'($urandom_range(0, 31));
          cin[u][v] = (b % 2 == 0) ? 9'($urandom_range(0, 511)) : ($urandom_range(0, 3) == 0 ? 9'(sm) : 9'sd0);
        end
      model();
      run_block(lat, be);
      checks++; if (lat != 16 || be != 0) begin errors++; $display("FAIL rand_timing block %0d lat %0d busy_err %0d want 16 0", b, lat, be); end
      nb = pix_diff();
      checks++; if (nb != 0) begin errors++; $display("FAIL rand_pixels block %0d [%0d][%0d] got %0d want %0d", b, bad_m, bad_n, bus.pixels_out[bad_m][bad_n], exp_pix[bad_m][bad_n]); end
    end
  endtask

  initial begin
    real x;
    bus.start_block = 1'b0;
    for (int u = 0; u < 8; u++)
      for (int v = 0; v < 8; v++) bus.quantized_coeffs[u][v] = '0;
    for (int k = 0; k < 8; k++)
      for (int n = 0; n < 8; n++) begin
        x = (k == 0 ? 256.0 * $sqrt(0.125) : 128.0) * $cos((2 * n + 1) * k * 3.14159265358979 / 16.0);
        cm[k][n] = x >= 0.0 ? longint'($rtoi(x + 0.5)) : -longint'($rtoi(0.5 - x));
      end
    test_reset();
    test_dc();
    test_ac();
    test_back_to_back();
    test_saturation();
    test_start_held();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
